// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM:SS clock controller.
//   - state encoding (RUN..SET_AL_MIN, 3 bits, also driven on set_mode)
//   - BCD field limits for the two-digit counters
//   - digit positions inside blank_mask and a helper that maps a set
//     state to the pair of digits it edits
package clock_pkg;

   typedef enum logic [2:0] {
      RUN        = 3'd0,
      SET_HR     = 3'd1,
      SET_MIN    = 3'd2,
      SET_SEC    = 3'd3,
      SET_AL_HR  = 3'd4,
      SET_AL_MIN = 3'd5
   } state_e;

   localparam logic [7:0] HR_MAX = 8'h23;
   localparam logic [7:0] MS_MAX = 8'h59;

   localparam int DIG_S_UNITS = 0;
   localparam int DIG_S_TENS  = 1;
   localparam int DIG_M_UNITS = 2;
   localparam int DIG_M_TENS  = 3;
   localparam int DIG_H_UNITS = 4;
   localparam int DIG_H_TENS  = 5;

   // Digits belonging to the field edited in state s (all zero in RUN).
   // Alarm states reuse the hour/minute positions because the alarm is
   // shown there while it is being edited.
   function automatic logic [5:0] field_mask(state_e s);
      logic [5:0] m;
      m = '0;
      case (s)
         SET_HR, SET_AL_HR: begin
            m[DIG_H_TENS]  = 1'b1;
            m[DIG_H_UNITS] = 1'b1;
         end
         SET_MIN, SET_AL_MIN: begin
            m[DIG_M_TENS]  = 1'b1;
            m[DIG_M_UNITS] = 1'b1;
         end
         SET_SEC: begin
            m[DIG_S_TENS]  = 1'b1;
            m[DIG_S_UNITS] = 1'b1;
         end
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter, 00..max, wrapping to 00.
// Ports:
//   clk, rst  clock and synchronous active-high reset (value -> 00)
//   max       highest value as packed BCD (e.g. 8'h23, 8'h59)
//   inc       advance by one this cycle
//   clr       synchronous clear to 00 (takes priority over inc)
//   val       current value {tens, units}
//   wrap      high in the cycle an inc takes the value from max to 00
module bcd2_counter
   import clock_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] max,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] val,
   output logic       wrap
);

   logic [7:0] val_q, val_d;

   always_comb begin
      val_d = val_q;
      wrap  = 1'b0;
      if (clr) begin
         val_d = 8'h00;
      end else if (inc) begin
         if (val_q == max) begin
            val_d = 8'h00;
            wrap  = 1'b1;
         end else if (val_q[3:0] == 4'd9) begin
            val_d = {val_q[7:4] + 4'd1, 4'd0};
         end else begin
            val_d = {val_q[7:4], val_q[3:0] + 4'd1};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) val_q <= 8'h00;
      else     val_q <= val_d;
   end

   assign val = val_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// Mode and time-keeping controller for the HH:MM:SS clock.
// Optional alarm support is compiled in with the CLOCK_ALARM_EN macro.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   tick        one-cycle pulse, TICKS_PER_SEC per second
//   btn_mode    mode button level (debounced)
//   btn_inc     increment button level (debounced)
//   al_en       alarm enable switch (only meaningful with CLOCK_ALARM_EN)
//   time_bcd    {h_tens,h_units,m_tens,m_units,s_tens,s_units}
//   blank_mask  1 = blank digit, bit 5 = h_tens .. bit 0 = s_units
//   set_mode    current state encoding
//   sec_pulse   one-cycle pulse when seconds advance in RUN
//   alarm_hit   alarm active (always 0 without CLOCK_ALARM_EN)
module clock_time_ctrl
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 10,
   parameter int BLINK_TICKS   = 5
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        btn_mode,
   input  logic        btn_inc,
   input  logic        al_en,
   output logic [23:0] time_bcd,
   output logic [5:0]  blank_mask,
   output logic [2:0]  set_mode,
   output logic        sec_pulse,
   output logic        alarm_hit
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   logic          mode_lvl_q, mode_lvl_d, inc_lvl_q, inc_lvl_d;
   logic          mode_edge_q, mode_edge_d, inc_edge_q, inc_edge_d;
   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_q, blink_d;
   logic          sec_pulse_q, sec_pulse_d;
   logic [5:0]    blank_mask_q, blank_mask_d;
   logic          alarm_hit_q, alarm_hit_d;

   logic          in_run, in_set, inc_ok, sec_tick;
   logic          sec_inc, min_inc, hr_inc, sec_wrap, min_wrap, unused_hr_wrap;
   logic [7:0]    sec_bcd, min_bcd, hr_bcd;

   bcd2_counter u_sec (.clk(clk), .rst(rst), .max(MS_MAX), .inc(sec_inc),
                       .clr(1'b0), .val(sec_bcd), .wrap(sec_wrap));
   bcd2_counter u_min (.clk(clk), .rst(rst), .max(MS_MAX), .inc(min_inc),
                       .clr(1'b0), .val(min_bcd), .wrap(min_wrap));
   bcd2_counter u_hr  (.clk(clk), .rst(rst), .max(HR_MAX), .inc(hr_inc),
                       .clr(1'b0), .val(hr_bcd),  .wrap(unused_hr_wrap));

`ifdef CLOCK_ALARM_EN
   logic       al_hr_inc, al_min_inc, unused_al_hr_wrap, unused_al_min_wrap;
   logic [7:0] al_hr_bcd, al_min_bcd;

   bcd2_counter u_al_hr  (.clk(clk), .rst(rst), .max(HR_MAX), .inc(al_hr_inc),
                          .clr(1'b0), .val(al_hr_bcd), .wrap(unused_al_hr_wrap));
   bcd2_counter u_al_min (.clk(clk), .rst(rst), .max(MS_MAX), .inc(al_min_inc),
                          .clr(1'b0), .val(al_min_bcd), .wrap(unused_al_min_wrap));

   assign al_hr_inc  = (state_q == SET_AL_HR)  & inc_ok;
   assign al_min_inc = (state_q == SET_AL_MIN) & inc_ok;
`else
   logic unused_al_en;
   assign unused_al_en = al_en;
`endif

   assign in_run   = (state_q == RUN);
   assign in_set   = ~in_run;
   // A mode edge swallows a coincident inc edge.
   assign inc_ok   = inc_edge_q & ~mode_edge_q;
   // RUN ticks are honoured even when a mode edge lands in the same cycle.
   assign sec_tick = in_run & tick & (presc_q == PRESC_LAST);

   // Set modes edit one field without carrying; RUN chains the wraps.
   assign sec_inc = sec_tick | ((state_q == SET_SEC) & inc_ok);
   assign min_inc = (in_run & sec_wrap) | ((state_q == SET_MIN) & inc_ok);
   assign hr_inc  = (in_run & min_wrap) | ((state_q == SET_HR)  & inc_ok);

   always_comb begin
      mode_lvl_d  = btn_mode;
      inc_lvl_d   = btn_inc;
      mode_edge_d = btn_mode & ~mode_lvl_q;
      inc_edge_d  = btn_inc  & ~inc_lvl_q;

      state_d = state_q;
      if (mode_edge_q) begin
         case (state_q)
            RUN:        state_d = SET_HR;
            SET_HR:     state_d = SET_MIN;
            SET_MIN:    state_d = SET_SEC;
`ifdef CLOCK_ALARM_EN
            SET_SEC:    state_d = SET_AL_HR;
            SET_AL_HR:  state_d = SET_AL_MIN;
`endif
            default:    state_d = RUN;
         endcase
      end

      // Held at 0 outside RUN, so re-entering RUN gives a full second.
      presc_d = presc_q;
      if (state_d != RUN)           presc_d = '0;
      else if (in_run && tick)      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;

      // Any state change or applied edit restarts the blink visible.
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      if ((state_d != state_q) || !in_set || inc_ok) begin
         blink_cnt_d = '0;
         blink_d     = 1'b0;
      end else if (tick) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end

      blank_mask_d = blink_d ? field_mask(state_d) : 6'b000000;
      sec_pulse_d  = sec_tick;
`ifdef CLOCK_ALARM_EN
      alarm_hit_d  = al_en & in_run & ({hr_bcd, min_bcd} == {al_hr_bcd, al_min_bcd});
`else
      alarm_hit_d  = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // Track the live level so a button held through reset is no edge.
         mode_lvl_q   <= btn_mode;
         inc_lvl_q    <= btn_inc;
         mode_edge_q  <= 1'b0;
         inc_edge_q   <= 1'b0;
         state_q      <= RUN;
         presc_q      <= '0;
         blink_cnt_q  <= '0;
         blink_q      <= 1'b0;
         sec_pulse_q  <= 1'b0;
         blank_mask_q <= '0;
         alarm_hit_q  <= 1'b0;
      end else begin
         mode_lvl_q   <= mode_lvl_d;
         inc_lvl_q    <= inc_lvl_d;
         mode_edge_q  <= mode_edge_d;
         inc_edge_q   <= inc_edge_d;
         state_q      <= state_d;
         presc_q      <= presc_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_q      <= blink_d;
         sec_pulse_q  <= sec_pulse_d;
         blank_mask_q <= blank_mask_d;
         alarm_hit_q  <= alarm_hit_d;
      end
   end

   always_comb begin
      time_bcd = {hr_bcd, min_bcd, sec_bcd};
`ifdef CLOCK_ALARM_EN
      if (state_q == SET_AL_HR || state_q == SET_AL_MIN)
         time_bcd = {al_hr_bcd, al_min_bcd, 8'h00};
`endif
   end

   assign blank_mask = blank_mask_q;
   assign set_mode   = state_q;
   assign sec_pulse  = sec_pulse_q;
   assign alarm_hit  = alarm_hit_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: a vector table, hand-written
// corner sequences and a randomized run, all compared against a model
// that keeps time as plain integers (hours/minutes/seconds).
module tb_clock_time_ctrl;

   localparam int TPS   = 10;
   localparam int BLINK = 5;
`ifdef CLOCK_ALARM_EN
   localparam int NST    = 6;
   localparam bit HAS_AL = 1'b1;
`else
   localparam int NST    = 4;
   localparam bit HAS_AL = 1'b0;
`endif
   localparam int OP_RST = 0, OP_TICK = 1, OP_MODE = 2, OP_INC = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick = 1'b0;
   logic        btn_mode = 1'b0;
   logic        btn_inc = 1'b0;
   logic        al_en = 1'b0;
   logic [23:0] time_bcd;
   logic [5:0]  blank_mask;
   logic [2:0]  set_mode;
   logic        sec_pulse;
   logic        alarm_hit;

   clock_time_ctrl #(.TICKS_PER_SEC(TPS), .BLINK_TICKS(BLINK)) dut (
      .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .al_en(al_en), .time_bcd(time_bcd), .blank_mask(blank_mask),
      .set_mode(set_mode), .sec_pulse(sec_pulse), .alarm_hit(alarm_hit));

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int pulse_cnt = 0;

   // Reference model state.
   int m_mode, m_h, m_m, m_s, m_sub, m_bt, m_alh, m_alm;
   bit m_alen = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   function automatic logic [7:0] bcd8(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic logic [23:0] exp_time();
      if (m_mode >= 4) return {bcd8(m_alh), bcd8(m_alm), 8'h00};
      return {bcd8(m_h), bcd8(m_m), bcd8(m_s)};
   endfunction

   function automatic logic [5:0] exp_mask();
      if (m_mode == 0 || ((m_bt / BLINK) % 2) == 0) return 6'b000000;
      case (m_mode)
         1, 4:    return 6'b110000;
         2, 5:    return 6'b001100;
         default: return 6'b000011;
      endcase
   endfunction

   function automatic logic exp_alarm();
      return HAS_AL && m_alen && m_mode == 0 && m_h == m_alh && m_m == m_alm;
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_sub = 0; m_bt = 0; m_alh = 0; m_alm = 0;
   endfunction

   // Returns 1 when this tick completes a second.
   function automatic bit model_tick();
      if (m_mode != 0) begin
         m_bt++;
         return 1'b0;
      end
      m_sub++;
      if (m_sub < TPS) return 1'b0;
      m_sub = 0;
      m_s++;
      if (m_s == 60) begin m_s = 0; m_m++; end
      if (m_m == 60) begin m_m = 0; m_h++; end
      if (m_h == 24) m_h = 0;
      return 1'b1;
   endfunction

   function automatic void model_mode();
      m_mode = (m_mode + 1) % NST;
      m_bt = 0;
      m_sub = 0;
   endfunction

   function automatic void model_inc();
      if (m_mode == 0) return;
      m_bt = 0;
      case (m_mode)
         1: m_h   = (m_h + 1) % 24;
         2: m_m   = (m_m + 1) % 60;
         3: m_s   = (m_s + 1) % 60;
         4: m_alh = (m_alh + 1) % 24;
         default: m_alm = (m_alm + 1) % 60;
      endcase
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ".time"},  32'(time_bcd),   32'(exp_time()));
      chk({tag, ".mask"},  32'(blank_mask), 32'(exp_mask()));
      chk({tag, ".mode"},  32'(set_mode),   32'(m_mode));
      chk({tag, ".alarm"}, 32'(alarm_hit),  32'(exp_alarm()));
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      model_reset();
      @(posedge clk); @(negedge clk);
   endtask

   task automatic do_tick();
      bit p;
      @(negedge clk); tick = 1'b1;
      @(posedge clk);
      @(negedge clk); tick = 1'b0;
      p = model_tick();
      chk("sec_pulse", 32'(sec_pulse), 32'(p));
      if (sec_pulse) pulse_cnt++;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic press(input bit is_inc);
      @(negedge clk);
      if (is_inc) btn_inc = 1'b1; else btn_mode = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); btn_inc = 1'b0; btn_mode = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (is_inc) model_inc(); else model_mode();
   endtask

   task automatic set_alen(input bit v);
      @(negedge clk); al_en = v; m_alen = v;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_op(input int op);
      case (op)
         OP_RST:  do_reset();
         OP_TICK: do_tick();
         OP_MODE: press(1'b0);
         default: press(1'b1);
      endcase
   endtask

   typedef struct {
      int         op;
      int         n;
      logic [23:0] t;
      logic [5:0]  mask;
      logic [2:0]  mode;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      model_reset();

      // Vector table: operation repeated n times, then expected outputs.
      tbl.push_back('{OP_RST,  1,       24'h000000, 6'b000000, 3'd0});
      tbl.push_back('{OP_TICK, 9,       24'h000000, 6'b000000, 3'd0});
      tbl.push_back('{OP_TICK, 1,       24'h000001, 6'b000000, 3'd0});
      tbl.push_back('{OP_MODE, 1,       24'h000001, 6'b000000, 3'd1});
      tbl.push_back('{OP_INC,  23,      24'h230001, 6'b000000, 3'd1});
      tbl.push_back('{OP_MODE, 1,       24'h230001, 6'b000000, 3'd2});
      tbl.push_back('{OP_INC,  59,      24'h235901, 6'b000000, 3'd2});
      tbl.push_back('{OP_MODE, 1,       24'h235901, 6'b000000, 3'd3});
      tbl.push_back('{OP_INC,  58,      24'h235959, 6'b000000, 3'd3});
      tbl.push_back('{OP_MODE, NST - 3, 24'h235959, 6'b000000, 3'd0});
      tbl.push_back('{OP_TICK, 9,       24'h235959, 6'b000000, 3'd0});
      tbl.push_back('{OP_TICK, 1,       24'h000000, 6'b000000, 3'd0});
      tbl.push_back('{OP_MODE, 2,       24'h000000, 6'b000000, 3'd2});
      tbl.push_back('{OP_INC,  59,      24'h005900, 6'b000000, 3'd2});
      tbl.push_back('{OP_INC,  1,       24'h000000, 6'b000000, 3'd2});
      tbl.push_back('{OP_TICK, 30,      24'h000000, 6'b000000, 3'd2});
      tbl.push_back('{OP_TICK, 5,       24'h000000, 6'b001100, 3'd2});
      tbl.push_back('{OP_INC,  1,       24'h000100, 6'b000000, 3'd2});
      tbl.push_back('{OP_RST,  1,       24'h000000, 6'b000000, 3'd0});

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].n; k++) do_op(tbl[i].op);
         $display("vec %0d op=%0d n=%0d time=%06h mask=%06b mode=%0d",
                  i, tbl[i].op, tbl[i].n, time_bcd, blank_mask, set_mode);
         chk($sformatf("vec%0d.time", i), 32'(time_bcd),   32'(tbl[i].t));
         chk($sformatf("vec%0d.mask", i), 32'(blank_mask), 32'(tbl[i].mask));
         chk($sformatf("vec%0d.mode", i), 32'(set_mode),   32'(tbl[i].mode));
         chk($sformatf("vec%0d.pulse", i), 32'(sec_pulse), 32'(0));
         check_model($sformatf("vec%0d.model", i));
      end

      // Exactly one sec_pulse in the first second after reset.
      do_reset();
      pulse_cnt = 0;
      for (int k = 0; k < TPS; k++) do_tick();
      $display("seq pulse_count=%0d time=%06h", pulse_cnt, time_bcd);
      chk("pulse_count", 32'(pulse_cnt), 32'(1));
      chk("first_second", 32'(time_bcd), 32'h000001);

      // Blink in SET_HR, then an edit forces the digits visible.
      do_reset();
      press(1'b0);
      for (int k = 0; k < BLINK - 1; k++) do_tick();
      chk("blink_before", 32'(blank_mask), 32'(6'b000000));
      do_tick();
      chk("blink_on", 32'(blank_mask), 32'(6'b110000));
      for (int k = 0; k < BLINK; k++) do_tick();
      chk("blink_off", 32'(blank_mask), 32'(6'b000000));
      for (int k = 0; k < BLINK; k++) do_tick();
      chk("blink_on2", 32'(blank_mask), 32'(6'b110000));
      press(1'b1);
      $display("seq blink time=%06h mask=%06b", time_bcd, blank_mask);
      chk("blink_after_inc", 32'(blank_mask), 32'(6'b000000));
      chk("blink_inc_time", 32'(time_bcd), 32'h010000);
      check_model("blink.model");

      // Mode and inc edges together from RUN: mode wins.
      do_reset();
      @(negedge clk); btn_mode = 1'b1; btn_inc = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); btn_mode = 1'b0; btn_inc = 1'b0;
      repeat (2) @(posedge clk); @(negedge clk);
      model_mode();
      $display("seq mode+inc mode=%0d time=%06h", set_mode, time_bcd);
      chk("both_mode", 32'(set_mode), 32'(1));
      chk("both_time", 32'(time_bcd), 32'h000000);
      // Holding inc for 20 cycles gives a single increment.
      @(negedge clk); btn_inc = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk); btn_inc = 1'b0;
      repeat (2) @(posedge clk); @(negedge clk);
      model_inc();
      $display("seq hold_inc time=%06h", time_bcd);
      chk("hold_inc_time", 32'(time_bcd), 32'h010000);
      check_model("hold.model");

      // tick + mode edge in RUN: the tick completes the second, state moves.
      do_reset();
      for (int k = 0; k < TPS - 1; k++) do_tick();
      @(negedge clk); btn_mode = 1'b1;
      @(posedge clk);
      @(negedge clk); tick = 1'b1;
      @(posedge clk);
      @(negedge clk); tick = 1'b0;
      chk("tick_mode_pulse", 32'(sec_pulse), 32'(1));
      void'(model_tick());
      model_mode();
      btn_mode = 1'b0;
      repeat (2) @(posedge clk); @(negedge clk);
      $display("seq tick+mode mode=%0d time=%06h", set_mode, time_bcd);
      chk("tick_mode_time", 32'(time_bcd), 32'h000001);
      chk("tick_mode_state", 32'(set_mode), 32'(1));
      check_model("tick_mode.model");

      // tick + inc edge in SET_SEC: only the inc counts (blink ignores the tick).
      do_reset();
      for (int k = 0; k < 3; k++) press(1'b0);
      @(negedge clk); btn_inc = 1'b1;
      @(posedge clk);
      @(negedge clk); tick = 1'b1;
      @(posedge clk);
      @(negedge clk); tick = 1'b0;
      chk("tick_inc_pulse", 32'(sec_pulse), 32'(0));
      model_inc();
      btn_inc = 1'b0;
      repeat (2) @(posedge clk); @(negedge clk);
      $display("seq tick+inc time=%06h mask=%06b", time_bcd, blank_mask);
      chk("tick_inc_time", 32'(time_bcd), 32'h000001);
      for (int k = 0; k < BLINK - 1; k++) do_tick();
      chk("tick_inc_mask0", 32'(blank_mask), 32'(6'b000000));
      do_tick();
      chk("tick_inc_mask1", 32'(blank_mask), 32'(6'b000011));

      // Button held through reset produces no edge.
      @(negedge clk); btn_mode = 1'b1; rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      model_reset();
      repeat (4) @(posedge clk); @(negedge clk);
      $display("seq held_reset mode=%0d", set_mode);
      chk("held_reset_mode", 32'(set_mode), 32'(0));
      btn_mode = 1'b0;
      repeat (2) @(posedge clk); @(negedge clk);
      check_model("held_reset.model");

`ifdef CLOCK_ALARM_EN
      // Alarm at 07:30 with time 07:29:59.
      do_reset();
      press(1'b0); for (int k = 0; k < 7;  k++) press(1'b1);
      press(1'b0); for (int k = 0; k < 29; k++) press(1'b1);
      press(1'b0); for (int k = 0; k < 59; k++) press(1'b1);
      press(1'b0); for (int k = 0; k < 7;  k++) press(1'b1);
      press(1'b0); for (int k = 0; k < 30; k++) press(1'b1);
      chk("alarm_show", 32'(time_bcd), 32'h073000);
      press(1'b0);
      set_alen(1'b1);
      chk("alarm_before", 32'(alarm_hit), 32'(0));
      for (int k = 0; k < TPS; k++) do_tick();
      $display("seq alarm time=%06h hit=%0d", time_bcd, alarm_hit);
      chk("alarm_rise", 32'(alarm_hit), 32'(1));
      set_alen(1'b0);
      chk("alarm_off", 32'(alarm_hit), 32'(0));
      check_model("alarm.model");
`endif

      // Randomized run against the model.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 65)       do_tick();
         else if (r < 77)  press(1'b0);
         else if (r < 94)  press(1'b1);
         else if (r < 99)  set_alen(~m_alen);
         else              do_reset();
         $display("rnd %0d r=%0d time=%06h mask=%06b mode=%0d hit=%0d",
                  i, r, time_bcd, blank_mask, set_mode, alarm_hit);
         check_model($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Mode and time-keeping controller for the board's HH:MM:SS digital clock.
- Owns the BCD time registers and the run/set state machine.
- Takes a periodic tick and two button levels; produces the 24-bit BCD time word for the 7-segment drivers, plus a per-digit blank mask that blinks the field being edited.
- Replaces hand-wired load/enable chaining of discrete counters with one sequenced block.

Parameters:
- TICKS_PER_SEC, 10, number of tick pulses per second (tick source is the 100 ms divider).
- BLINK_TICKS, 5, ticks per blink half-period in set modes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-cycle pulse from the clock divider.
- btn_mode  in  1  mode button level, debounced upstream.
- btn_inc  in  1  increment button level, debounced upstream.
- al_en  in  1  alarm enable switch; used only with CLOCK_ALARM_EN.
- time_bcd  out  24  {h_tens, h_units, m_tens, m_units, s_tens, s_units}, 4 bits each.
- blank_mask  out  6  1 = blank digit; bit 5 = h_tens ... bit 0 = s_units.
- set_mode  out  3  current state encoding, for LEDs/debug.
- sec_pulse  out  1  one-cycle pulse when seconds advance in RUN.
- alarm_hit  out  1  alarm active.

Behaviour:
- Reset (rst=1 at a clk edge):
  - time_bcd = 24'h000000; state RUN; prescaler 0; blink phase 0.
  - blank_mask = 0; sec_pulse = 0; alarm_hit = 0.
  - Button edge registers cleared, so a button held through reset does not produce an edge.
- Button handling: each button is registered once and rising-edge detected into a one-cycle internal pulse. Time and state updates appear one cycle after that pulse (registered).
- States: RUN(0), SET_HR(1), SET_MIN(2), SET_SEC(3). Each mode edge advances RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
- RUN:
  - Prescaler counts ticks 0..TICKS_PER_SEC-1.
  - On wrap: seconds increment and sec_pulse is asserted that cycle.
  - BCD rules:
    - units 9 -> 0 carries into tens.
    - seconds 59 -> 00 carries into minutes.
    - minutes 59 -> 00 carries into hours.
    - hours 23 -> 00; no day carry.
  - No digit ever holds a value >9; tens never exceed 5 for minutes/seconds or 2 for hours.
- SET_x:
  - Prescaler held at 0; time does not advance from tick.
  - An inc edge increments the selected field with wrap: hours 23 -> 00, minutes/seconds 59 -> 00. No carry into the next field.
  - Leaving SET_SEC for RUN restarts the prescaler from 0, giving a full second before the first advance.
- Blink:
  - In set states, blink phase toggles every BLINK_TICKS ticks.
  - blank_mask marks the two digits of the selected field when phase = 1, otherwise 0.
  - blank_mask = 0 in RUN.
  - Phase resets to 0 on every state change and every inc edge, so the digit is visible immediately after an edit.
- Simultaneous events:
  - Mode edge + inc edge in the same cycle: mode wins, inc discarded.
  - tick + mode edge while in RUN: the tick is processed under RUN; the state changes in the same update.
  - tick + inc edge in a set state: only the inc is applied.
- Reset mid-edit returns to RUN at 00:00:00.

Optional Feature:
- Macro: CLOCK_ALARM_EN.
- With the macro:
  - Adds alarm hour/minute BCD registers, reset to 00:00.
  - Adds states SET_AL_HR(4) and SET_AL_MIN(5) after SET_SEC; the mode cycle becomes ... SET_SEC -> SET_AL_HR -> SET_AL_MIN -> RUN.
  - While in an alarm state, time_bcd shows the alarm as {alarm_hh, alarm_mm, 8'h00}.
  - alarm_hit = al_en & (state == RUN) & (hh:mm == alarm hh:mm), registered. It is therefore high for the whole matching minute.
- Without the macro: alarm states and registers are absent, alarm_hit is tied to 0, and al_en is ignored.

Decomposition:
- Package clock_pkg:
  - State encoding constants RUN..SET_AL_MIN (3-bit).
  - BCD limits HR_MAX = 8'h23 and MS_MAX = 8'h59.
  - Digit-field index constants for blank_mask.
- Sub-module bcd2_counter:
  - Two-digit BCD counter with a MAX input, inc and clr inputs, and a wrap/carry output.
  - Instantiated three times (hours, minutes, seconds), plus twice more under CLOCK_ALARM_EN.

Test Plan:
- Reset, then 10 ticks in RUN -> time_bcd = 24'h000001 and exactly one sec_pulse.
- Preload via set modes to 23:59:59, return to RUN, apply 10 ticks -> time_bcd = 24'h000000 with correct units/tens rollover at every field.
- SET_MIN at 59, one inc edge -> minutes = 00 and hours unchanged. Ticks during SET_MIN -> time frozen.
- SET_HR with blink: blank_mask toggles 6'b110000 / 6'b000000 every 5 ticks; an inc edge forces 6'b000000 immediately.
- Mode and inc edges in the same cycle from RUN -> state = SET_HR and time unchanged. Holding btn_inc high for 20 cycles -> exactly one increment.
- CLOCK_ALARM_EN: alarm 07:30, al_en = 1, time 07:29:59 + 1 s -> alarm_hit rises; it falls at 07:31:00 or when al_en drops.
